pwm_multichannel: RTL and testbench

- Parametrised successor to the single-duty 16-output PWM peripheral.
- Each channel has its own duty cycle. Counter width and channel count are parameters, and a programmable prescaler and period sit in front of the counter.
- Duty updates are double-buffered and take effect only at period boundaries, so no glitched pulses.
- Sits between the SPI register file and the chip output pins; output-enable and PWM-enable masks come straight from the register file.

---
 rtl/pwm_multichannel.sv | 213 +++++++++++++++++++++
 tb/tb_pwm_multichannel.sv | 486 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_multichannel.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_multichannel
//  Description : Multi-channel PWM generator. A shared prescaler and period
//                counter drive NUM_CH comparators, each with its own
//                double-buffered duty register. Shadow duties written from
//                the register file are copied to the active duties only at
//                the period boundary, so a pulse is never cut short or
//                stretched mid-period. Outputs are registered.
//                Optional feature macro: PWM_CENTER_ALIGNED_EN
//                  undefined : edge-aligned counter 0..period_max
//                  defined   : up/down counter 0..period_max..0, reload at
//                              the bottom of the count
//  Revision    : 1.0 - initial release
// ============================================================================
module pwm_multichannel #(
    parameter  int NUM_CH  = 16,
    parameter  int CNT_W   = 8,
    parameter  int PRESC_W = 12,
    localparam int CH_AW   = $clog2(NUM_CH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [PRESC_W-1:0] presc_div,
    input  logic [CNT_W-1:0]   period_max,
    input  logic [NUM_CH-1:0]  en_out,
    input  logic [NUM_CH-1:0]  en_pwm,
    input  logic               duty_wr_en,
    input  logic [CH_AW-1:0]   duty_wr_ch,
    input  logic [CNT_W-1:0]   duty_wr_data,
    output logic [NUM_CH-1:0]  pwm_out,
    output logic               period_tick
);

    // Channel count widened by one bit so the range check also works when
    // NUM_CH is an exact power of two.
    localparam logic [CH_AW:0] c_num_ch = (CH_AW + 1)'(NUM_CH);

    // ------------------------------------------------------------------------
    // Prescaler
    // ------------------------------------------------------------------------
    logic [PRESC_W-1:0] pre_cnt_q;
    logic [PRESC_W-1:0] pre_cnt_d;
    logic               w_tick;

    // A ">=" compare lets a shrinking presc_div take effect immediately
    // instead of waiting for the counter to wrap around its full width.
    always_comb begin
        w_tick    = (pre_cnt_q >= presc_div);
        pre_cnt_d = w_tick ? '0 : (pre_cnt_q + PRESC_W'(1));
    end

    // Prescaler count register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pre_cnt_q <= '0;
        end else begin
            pre_cnt_q <= pre_cnt_d;
        end
    end

    // ------------------------------------------------------------------------
    // Period counter and reload strobe
    // ------------------------------------------------------------------------
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             w_reload;

`ifdef PWM_CENTER_ALIGNED_EN
    typedef enum logic [0:0] {
        DIR_UP = 1'b0,
        DIR_DN = 1'b1
    } dir_t;

    dir_t dir_q;
    dir_t dir_d;
    logic first_q;
    logic first_d;

    // Up/down count. The boundary is the bottom of the down slope, plus the
    // very first tick after reset so the initial duties load straight away.
    always_comb begin
        cnt_d    = cnt_q;
        dir_d    = dir_q;
        first_d  = first_q;
        w_reload = 1'b0;
        if (w_tick) begin
            first_d  = 1'b0;
            w_reload = first_q || ((dir_q == DIR_DN) && (cnt_q == '0));
            if (period_max == '0) begin
                // Degenerate period: hold at zero and reload on every tick.
                cnt_d = '0;
                dir_d = DIR_DN;
            end else if (dir_q == DIR_UP) begin
                if (cnt_q >= period_max) begin
                    dir_d = DIR_DN;
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end else begin
                if (cnt_q == '0) begin
                    dir_d = DIR_UP;
                    cnt_d = CNT_W'(1);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
        end
    end

    // Counter, direction and first-tick registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            dir_q   <= DIR_UP;
            first_q <= 1'b1;
        end else begin
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            first_q <= first_d;
        end
    end
`else
    // Edge-aligned count. ">=" again avoids a lockup when period_max is
    // reduced below the current count.
    always_comb begin
        cnt_d    = cnt_q;
        w_reload = 1'b0;
        if (w_tick) begin
            if (cnt_q >= period_max) begin
                cnt_d    = '0;
                w_reload = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Period counter register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    // ------------------------------------------------------------------------
    // Per-channel duty buffers and comparators
    // ------------------------------------------------------------------------
    logic             w_wr_ok;
    logic [NUM_CH-1:0] w_raw;

    // Writes to channel indices that do not exist are dropped.
    assign w_wr_ok = duty_wr_en && ({1'b0, duty_wr_ch} < c_num_ch);

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        logic [CNT_W-1:0] shadow_q;
        logic [CNT_W-1:0] active_q;
        logic             w_sel;

        assign w_sel = w_wr_ok && (duty_wr_ch == CH_AW'(gi));

        // Shadow takes register-file writes; active copies the shadow only at
        // the boundary. Both are non-blocking, so a write landing in the
        // reload clock is seen by the following boundary, not this one.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                shadow_q <= '0;
                active_q <= '0;
            end else begin
                if (w_reload) begin
                    active_q <= shadow_q;
                end
                if (w_sel) begin
                    shadow_q <= duty_wr_data;
                end
            end
        end

        // All-ones duty means always high even when period_max is all-ones,
        // where "cnt < duty" alone would drop low for one count.
        assign w_raw[gi] = (active_q == '1) ? 1'b1 : (cnt_q < active_q);
    end

    // ------------------------------------------------------------------------
    // Output stage
    // ------------------------------------------------------------------------
    logic [NUM_CH-1:0] pwm_out_q;
    logic [NUM_CH-1:0] pwm_out_d;

    // Static-high channels bypass the comparator; disabled channels read 0.
    assign pwm_out_d = en_out & (~en_pwm | w_raw);

    // Registered pins: masks and compare results reach the pins one clock
    // later, with no period-boundary synchronisation on the masks.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pwm_out_q <= '0;
        end else begin
            pwm_out_q <= pwm_out_d;
        end
    end

    assign pwm_out     = pwm_out_q;
    // Derived from registered state; gated so it reads 0 while in reset.
    assign period_tick = w_reload & rst_n;

endmodule

`default_nettype wire

// File: tb/tb_pwm_multichannel.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pwm_multichannel
//  Description : Self-checking bench for pwm_multichannel (edge-aligned
//                build). A 12-channel instance exercises the out-of-range
//                channel index. A behavioural model tracks prescaler, count
//                and duties as integers and predicts the pins each clock.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pwm_multichannel;

    localparam int NUM_CH  = 12;
    localparam int CNT_W   = 8;
    localparam int PRESC_W = 12;
    localparam int CH_AW   = $clog2(NUM_CH);
    localparam int MAXD    = (1 << CNT_W) - 1;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [PRESC_W-1:0] presc_div;
    logic [CNT_W-1:0]   period_max;
    logic [NUM_CH-1:0]  en_out;
    logic [NUM_CH-1:0]  en_pwm;
    logic               duty_wr_en;
    logic [CH_AW-1:0]   duty_wr_ch;
    logic [CNT_W-1:0]   duty_wr_data;
    logic [NUM_CH-1:0]  pwm_out;
    logic               period_tick;

    int checks   = 0;
    int failures = 0;

    pwm_multichannel #(
        .NUM_CH  (NUM_CH),
        .CNT_W   (CNT_W),
        .PRESC_W (PRESC_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .presc_div    (presc_div),
        .period_max   (period_max),
        .en_out       (en_out),
        .en_pwm       (en_pwm),
        .duty_wr_en   (duty_wr_en),
        .duty_wr_ch   (duty_wr_ch),
        .duty_wr_data (duty_wr_data),
        .pwm_out      (pwm_out),
        .period_tick  (period_tick)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------------
    // Reference model: integer ticks-per-period bookkeeping
    // ------------------------------------------------------------------------
    int                m_pre = 0;
    int                m_cnt = 0;
    int                m_shadow [NUM_CH];
    int                m_active [NUM_CH];
    logic [NUM_CH-1:0] m_out = '0;
    logic              m_t;
    logic              m_b;
    logic              m_tick;

    initial begin
        for (int i = 0; i < NUM_CH; i++) begin
            m_shadow[i] = 0;
            m_active[i] = 0;
        end
    end

    function automatic logic level(input int duty, input int c);
        return (duty == MAXD) ? 1'b1 : (c < duty);
    endfunction

    assign m_t    = (m_pre >= int'(presc_div));
    assign m_b    = m_t && (m_cnt >= int'(period_max));
    assign m_tick = rst_n && m_b;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_pre <= 0;
            m_cnt <= 0;
            m_out <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                m_shadow[i] <= 0;
                m_active[i] <= 0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                m_out[i] <= en_out[i] & (~en_pwm[i] | level(m_active[i], m_cnt));
            end
            m_pre <= m_t ? 0 : m_pre + 1;
            if (m_t) m_cnt <= m_b ? 0 : m_cnt + 1;
            if (m_b) begin
                for (int i = 0; i < NUM_CH; i++) m_active[i] <= m_shadow[i];
            end
            if (duty_wr_en && (int'(duty_wr_ch) < NUM_CH)) begin
                m_shadow[duty_wr_ch] <= int'(duty_wr_data);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus helpers (all activity starts just after a falling edge)
    // ------------------------------------------------------------------------
    task automatic drive_wr(input int ch, input int data);
        duty_wr_en   = 1'b1;
        duty_wr_ch   = CH_AW'(ch);
        duty_wr_data = CNT_W'(data);
        @(negedge clk);
        duty_wr_en   = 1'b0;
    endtask

    task automatic wait_tick(input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (period_tick === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // ------------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------------
    task automatic test_reset;
        rst_n        = 1'b0;
        presc_div    = '0;
        period_max   = 8'd255;
        en_out       = '1;
        en_pwm       = '1;
        duty_wr_en   = 1'b0;
        duty_wr_ch   = '0;
        duty_wr_data = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (pwm_out !== '0) begin
            failures++;
            $display("FAIL reset_pwm_out got=%h exp=0", pwm_out);
        end
        checks++;
        if (period_tick !== 1'b0) begin
            failures++;
            $display("FAIL reset_period_tick got=%b exp=0", period_tick);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (pwm_out !== '0 || period_tick !== 1'b0) begin
            failures++;
            $display("FAIL reset_release got=%h/%b exp=0/0", pwm_out, period_tick);
        end
    endtask

    task automatic test_basic;
        bit ok;
        int hi3;
        int oth;
        drive_wr(3, 128);
        wait_tick(600, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL basic_tick_timeout got=none exp=period_tick");
        end
        repeat (2) @(negedge clk);
        hi3 = 0;
        oth = 0;
        for (int k = 0; k < 256; k++) begin
            checks++;
            if (pwm_out !== m_out || period_tick !== m_tick) begin
                failures++;
                $display("FAIL basic_model t=%0t got=%h/%b exp=%h/%b", $time, pwm_out, period_tick, m_out, m_tick);
            end
            hi3 += int'(pwm_out[3]);
            if ((pwm_out & ~(NUM_CH'(1) << 3)) != '0) oth++;
            @(negedge clk);
        end
        checks++;
        if (hi3 != 128) begin
            failures++;
            $display("FAIL basic_ch3_high got=%0d exp=128", hi3);
        end
        checks++;
        if (oth != 0) begin
            failures++;
            $display("FAIL basic_others_high got=%0d exp=0", oth);
        end
    endtask

    task automatic test_extremes;
        bit ok;
        int hi [4];
        drive_wr(0, 0);
        drive_wr(1, 255);
        drive_wr(2, 1);
        wait_tick(600, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL extremes_tick_timeout got=none exp=period_tick");
        end
        repeat (2) @(negedge clk);
        for (int c = 0; c < 4; c++) hi[c] = 0;
        for (int k = 0; k < 256; k++) begin
            checks++;
            if (pwm_out !== m_out || period_tick !== m_tick) begin
                failures++;
                $display("FAIL extremes_model t=%0t got=%h/%b exp=%h/%b", $time, pwm_out, period_tick, m_out, m_tick);
            end
            for (int c = 0; c < 4; c++) hi[c] += int'(pwm_out[c]);
            @(negedge clk);
        end
        checks++;
        if (hi[0] != 0) begin
            failures++;
            $display("FAIL duty0_high got=%0d exp=0", hi[0]);
        end
        checks++;
        if (hi[1] != 256) begin
            failures++;
            $display("FAIL duty255_high got=%0d exp=256", hi[1]);
        end
        checks++;
        if (hi[2] != 1) begin
            failures++;
            $display("FAIL duty1_high got=%0d exp=1", hi[2]);
        end
        checks++;
        if (hi[3] != 128) begin
            failures++;
            $display("FAIL duty128_high got=%0d exp=128", hi[3]);
        end
    endtask

    task automatic test_glitch_free;
        bit ok;
        int c1;
        int c2;
        drive_wr(5, 64);
        wait_tick(600, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL glitch_tick_timeout got=none exp=period_tick");
        end
        repeat (2) @(negedge clk);
        c1 = 0;
        c2 = 0;
        for (int k = 0; k < 512; k++) begin
            if (k < 256) c1 += int'(pwm_out[5]);
            else         c2 += int'(pwm_out[5]);
            if (k == 100) begin
                duty_wr_en   = 1'b1;
                duty_wr_ch   = CH_AW'(5);
                duty_wr_data = 8'd192;
            end
            if (k == 101) duty_wr_en = 1'b0;
            @(negedge clk);
        end
        checks++;
        if (c1 != 64) begin
            failures++;
            $display("FAIL midwrite_cur_period got=%0d exp=64", c1);
        end
        checks++;
        if (c2 != 192) begin
            failures++;
            $display("FAIL midwrite_next_period got=%0d exp=192", c2);
        end
        // Write landing in the reload clock itself.
        wait_tick(600, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL reloadwr_tick_timeout got=none exp=period_tick");
        end
        duty_wr_en   = 1'b1;
        duty_wr_ch   = CH_AW'(5);
        duty_wr_data = 8'd32;
        @(negedge clk);
        duty_wr_en = 1'b0;
        @(negedge clk);
        c1 = 0;
        c2 = 0;
        for (int k = 0; k < 512; k++) begin
            if (k < 256) c1 += int'(pwm_out[5]);
            else         c2 += int'(pwm_out[5]);
            @(negedge clk);
        end
        checks++;
        if (c1 != 192) begin
            failures++;
            $display("FAIL reloadwr_same_period got=%0d exp=192", c1);
        end
        checks++;
        if (c2 != 32) begin
            failures++;
            $display("FAIL reloadwr_next_period got=%0d exp=32", c2);
        end
    endtask

    task automatic test_prescaler;
        bit ok;
        int n;
        int hi;
        presc_div  = 12'd3;
        period_max = 8'd9;
        drive_wr(8, 5);
        wait_tick(2000, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL presc_tick_timeout got=none exp=period_tick");
        end
        n = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            n++;
            if (period_tick === 1'b1) break;
        end
        checks++;
        if (n != 40) begin
            failures++;
            $display("FAIL presc_tick_interval got=%0d exp=40", n);
        end
        repeat (2) @(negedge clk);
        hi = 0;
        for (int k = 0; k < 40; k++) begin
            checks++;
            if (pwm_out !== m_out || period_tick !== m_tick) begin
                failures++;
                $display("FAIL presc_model t=%0t got=%h/%b exp=%h/%b", $time, pwm_out, period_tick, m_out, m_tick);
            end
            hi += int'(pwm_out[8]);
            @(negedge clk);
        end
        checks++;
        if (hi != 20) begin
            failures++;
            $display("FAIL presc_ch8_high got=%0d exp=20", hi);
        end
    endtask

    task automatic test_masks;
        int bad;
        logic [NUM_CH-1:0] zero_duty;
        zero_duty = 12'b1110_1101_0001;
        en_pwm[7] = 1'b0;
        @(negedge clk);
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            if (pwm_out[7] !== 1'b1) bad++;
            @(negedge clk);
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL static_high_ch7 got=%0d_low_samples exp=0", bad);
        end
        en_out[7] = 1'b0;
        @(negedge clk);
        checks++;
        if (pwm_out[7] !== 1'b0) begin
            failures++;
            $display("FAIL en_out_off_ch7 got=%b exp=0", pwm_out[7]);
        end
        en_out[7] = 1'b1;
        en_pwm[7] = 1'b1;
        drive_wr(12, 200);
        drive_wr(15, 99);
        bad = 0;
        for (int k = 0; k < 120; k++) begin
            checks++;
            if (pwm_out !== m_out || period_tick !== m_tick) begin
                failures++;
                $display("FAIL badaddr_model t=%0t got=%h/%b exp=%h/%b", $time, pwm_out, period_tick, m_out, m_tick);
            end
            if ((pwm_out & zero_duty) != '0) bad++;
            @(negedge clk);
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL badaddr_zero_channels got=%0d exp=0", bad);
        end
    endtask

    task automatic test_reset_mid;
        bit ok;
        int bad;
        int hi;
        presc_div  = '0;
        period_max = 8'd255;
        repeat (2) @(negedge clk);
        checks++;
        if (pwm_out[1] !== 1'b1) begin
            failures++;
            $display("FAIL pre_reset_ch1 got=%b exp=1", pwm_out[1]);
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checks++;
        if (pwm_out !== '0 || period_tick !== 1'b0) begin
            failures++;
            $display("FAIL midreset_outputs got=%h/%b exp=0/0", pwm_out, period_tick);
        end
        bad = 0;
        for (int k = 0; k < 600; k++) begin
            @(negedge clk);
            if (pwm_out !== '0) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL post_reset_low got=%0d_nonzero exp=0", bad);
        end
        drive_wr(2, 50);
        wait_tick(600, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL rewrite_tick_timeout got=none exp=period_tick");
        end
        repeat (2) @(negedge clk);
        hi = 0;
        for (int k = 0; k < 256; k++) begin
            hi += int'(pwm_out[2]);
            @(negedge clk);
        end
        checks++;
        if (hi != 50) begin
            failures++;
            $display("FAIL rewrite_ch2_high got=%0d exp=50", hi);
        end
    endtask

    task automatic test_random;
        for (int it = 0; it < 40; it++) begin
            presc_div  = PRESC_W'($urandom_range(0, 3));
            period_max = ($urandom_range(0, 3) == 0) ? 8'd255 : CNT_W'($urandom_range(0, 15));
            en_out     = NUM_CH'($urandom);
            en_pwm     = NUM_CH'($urandom);
            for (int k = 0; k < 100; k++) begin
                checks++;
                if (pwm_out !== m_out || period_tick !== m_tick) begin
                    failures++;
                    $display("FAIL random_model t=%0t got=%h/%b exp=%h/%b", $time, pwm_out, period_tick, m_out, m_tick);
                end
                duty_wr_en   = ($urandom_range(0, 3) == 0);
                duty_wr_ch   = CH_AW'($urandom_range(0, 15));
                duty_wr_data = ($urandom_range(0, 7) == 0) ? 8'd255 : CNT_W'($urandom_range(0, 20));
                rst_n        = ($urandom_range(0, 299) != 0);
                @(negedge clk);
            end
            rst_n      = 1'b1;
            duty_wr_en = 1'b0;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_basic();
        test_extremes();
        test_glitch_free();
        test_prescaler();
        test_masks();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
